shift_arbiter: RTL and testbench

- Shares one iterative bit-serial shifter between N_REQ requesters.
- Round-robin arbitration; each job moves its value one bit position per clock.
- Each requester gets a request/ack/done handshake and a common result bus.
- Sits between the I/O-device requesters and the shared shift datapath.
- Replaces the per-device free-running shifter: one shift in flight at a time, with explicit start and completion.

---
 rtl/shift_arb_pkg.sv | 18 +
 rtl/shift_core.sv | 57 +++++
 rtl/shift_arbiter.sv | 132 +++++++++++++
 tb/tb_shift_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_arb_pkg.sv
// shift_arb_pkg
//   Shared constants for the shift arbiter and its bit-serial shift core:
//   FSM state encoding, default datapath widths and shift-direction codes.
package shift_arb_pkg;

    // Default datapath sizes
    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 4;

    // Arbiter FSM states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Shift direction encoding on req_dir
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_core.sv
// shift_core
//   Iterative logical shifter: moves the loaded value one bit per step until
//   the remaining count reaches zero. Zero-filled, no sign extension.
//
// Ports:
//   clk         system clock
//   reset       synchronous active-low reset
//   load        capture load_value / load_dir / load_times
//   step        shift one position if count is nonzero
//   load_value  operand to shift
//   load_dir    DIR_LEFT or DIR_RIGHT
//   load_times  number of positions to shift
//   value       current (partially) shifted value
//   count_zero  no shifts remain; value is final
module shift_core
    import shift_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] load_value,
    input  logic             load_dir,
    input  logic [CNT_W-1:0] load_times,
    output logic [WIDTH-1:0] value,
    output logic             count_zero
);

    logic [CNT_W-1:0] count;
    logic             dir;

    // Counts of WIDTH or more need no special case: the serial shifting
    // walks every bit out and leaves zero behind.
    always_ff @(posedge clk) begin
        if (!reset) begin
            value <= '0;
            count <= '0;
            dir   <= DIR_LEFT;
        end else if (load) begin
            value <= load_value;
            count <= load_times;
            dir   <= load_dir;
        end else if (step && (count != '0)) begin
            case (dir)
                DIR_RIGHT: value <= value >> 1;
                default:   value <= value << 1;
            endcase
            count <= count - 1'b1;
        end
    end

    assign count_zero = (count == '0);

endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter
//   Shares one bit-serial shift_core between N_REQ requesters. A round-robin
//   pick in IDLE grants one requester, captures its operands and acks it;
//   the job then shifts one bit per clock and signals done with the result.
//
// Ports:
//   clk        system clock
//   reset      synchronous active-low reset (aborts any job silently)
//   req        per-requester level request, held until ack
//   req_value  operands, slice i = [i*WIDTH +: WIDTH]
//   req_dir    per-requester direction (1 = right, 0 = left)
//   req_times  shift counts, slice i = [i*CNT_W +: CNT_W]
//   ack        one-cycle pulse: request accepted, operands captured
//   done       one-cycle pulse: result valid for that requester
//   result     last completed result, held until the next completion
//   busy       a job is in flight
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_value,
    input  logic [N_REQ-1:0]       req_dir,
    input  logic [N_REQ*CNT_W-1:0] req_times,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH-1:0]       result,
    output logic                   busy
);

    localparam int OW = $clog2(N_REQ);

    logic [0:0]       state;
    logic [OW-1:0]    owner;
    logic [OW-1:0]    last_grant;
    logic [OW-1:0]    grant_idx;
    logic             grant_valid;
    logic             core_load;
    logic             core_step;
    logic [WIDTH-1:0] core_value;
    logic             core_zero;

    // Per-requester operand views
    logic [WIDTH-1:0] value_arr [N_REQ];
    logic [CNT_W-1:0] times_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign value_arr[g] = req_value[g*WIDTH +: WIDTH];
        assign times_arr[g] = req_times[g*CNT_W +: CNT_W];
    end

    // Round-robin pick: scan last_grant+1, +2, ... modulo N_REQ. The loop
    // runs farthest-first so the nearest requesting candidate is written last.
    int            cand;
    logic [OW-1:0] cand_idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = int'(last_grant) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            cand_idx = OW'(cand);
            if (req[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Arbitration happens only in IDLE; req activity during SHIFT is ignored.
    assign core_load = (state == ST_IDLE) && grant_valid;
    assign core_step = (state == ST_SHIFT);
    assign busy      = (state == ST_SHIFT);

    shift_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .load       (core_load),
        .step       (core_step),
        .load_value (value_arr[grant_idx]),
        .load_dir   (req_dir[grant_idx]),
        .load_times (times_arr[grant_idx]),
        .value      (core_value),
        .count_zero (core_zero)
    );

    // last_grant resets to the top index so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            owner      <= '0;
            last_grant <= OW'(N_REQ - 1);
            ack        <= '0;
            done       <= '0;
            result     <= '0;
        end else begin
            ack  <= '0;
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner          <= grant_idx;
                        ack[grant_idx] <= 1'b1;
                        state          <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Completion cycle: the core has no shifts left.
                    if (core_zero) begin
                        result      <= core_value;
                        done[owner] <= 1'b1;
                        last_grant  <= owner;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter
//   Directed scenarios followed by randomized traffic, all checked every
//   cycle against a job-level reference model (grant by rotating priority,
//   completion at a computed cycle, result by a plain shift expression).
module tb_shift_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_value;
    logic [N_REQ-1:0]       req_dir;
    logic [N_REQ*CNT_W-1:0] req_times;
    logic [N_REQ-1:0]       ack;
    logic [N_REQ-1:0]       done;
    logic [WIDTH-1:0]       result;
    logic                   busy;

    shift_arbiter #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_value (req_value),
        .req_dir   (req_dir),
        .req_times (req_times),
        .ack       (ack),
        .done      (done),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    bit               m_idle;
    int               m_owner;
    int               m_last;
    int               m_done_cyc;
    logic [WIDTH-1:0] m_pend;
    logic [WIDTH-1:0] m_result;
    logic [N_REQ-1:0] m_ack;
    logic [N_REQ-1:0] m_done;
    bit               auto_drop = 1'b1;

    // DUT-observed ack log
    int obs_idx[$];
    int obs_cyc[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] v, input logic d, input int t);
        if (t >= WIDTH) return '0;
        return d ? (v >> t) : (v << t);
    endfunction

    task automatic set_ops(input int i, input logic [WIDTH-1:0] v, input logic d, input logic [CNT_W-1:0] t);
        req_value[i*WIDTH +: WIDTH] = v;
        req_dir[i]                  = d;
        req_times[i*CNT_W +: CNT_W] = t;
    endtask

    // What the next rising edge does, given the inputs now applied.
    task automatic model_edge();
        int w;
        int t;
        cyc++;
        m_ack  = '0;
        m_done = '0;
        if (!reset) begin
            m_idle   = 1'b1;
            m_last   = N_REQ - 1;
            m_owner  = 0;
            m_result = '0;
        end else if (m_idle) begin
            w = -1;
            for (int k = 1; k <= N_REQ; k++)
                if (w < 0 && req[(m_last + k) % N_REQ]) w = (m_last + k) % N_REQ;
            if (w >= 0) begin
                t          = int'(req_times[w*CNT_W +: CNT_W]);
                m_owner    = w;
                m_pend     = ref_shift(req_value[w*WIDTH +: WIDTH], req_dir[w], t);
                m_done_cyc = cyc + t + 1;
                m_ack[w]   = 1'b1;
                m_idle     = 1'b0;
            end
        end else if (cyc == m_done_cyc) begin
            m_result        = m_pend;
            m_done[m_owner] = 1'b1;
            m_last          = m_owner;
            m_idle          = 1'b1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk);
        chk("ack", ack, m_ack);
        chk("done", done, m_done);
        chk("result", result, m_result);
        chk("busy", busy, !m_idle);
        for (int i = 0; i < N_REQ; i++)
            if (ack[i]) begin
                obs_idx.push_back(i);
                obs_cyc.push_back(cyc);
            end
        if (auto_drop) req = req & ~m_ack;
    endtask

    task automatic drain();
        auto_drop = 1'b1;
        for (int n = 0; n < 400 && !(m_idle && req == '0); n++) tick();
        if (!(m_idle && req == '0)) chk("drain_timeout", 0, 1);
    endtask

    int exp4[5] = '{0, 1, 2, 3, 0};

    initial begin
        reset     = 1'b0;
        req       = '1;
        req_value = '0;
        req_dir   = '0;
        req_times = '0;

        // 1: reset held with all requesting, then requester 0 first
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("t1_first_ack", ack, 4'b0001);
        drain();

        // 2: single left shift by 4
        set_ops(1, 16'h00F0, 1'b0, 4'd4);
        req = 4'b0010;
        tick();
        chk("t2_ack", ack, 4'b0010);
        repeat (4) tick();
        tick();
        chk("t2_done", done, 4'b0010);
        chk("t2_result", result, 16'h0F00);
        drain();

        // 3: zero-count job completes one cycle after ack
        set_ops(2, 16'hA5A5, 1'b1, 4'd0);
        req = 4'b0100;
        tick();
        chk("t3_ack", ack, 4'b0100);
        tick();
        chk("t3_done", done, 4'b0100);
        chk("t3_result", result, 16'hA5A5);
        drain();

        // 4: all requesting continuously from reset, times=1
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < N_REQ; i++) set_ops(i, 16'h1234 + 16'(i), 1'b0, 4'd1);
        obs_idx.delete();
        obs_cyc.delete();
        auto_drop = 1'b0;
        req = '1;
        repeat (13) tick();
        req = '0;
        drain();
        chk("t4_grants", obs_idx.size() >= 5, 1'b1);
        for (int j = 0; j < 5; j++)
            if (j < obs_idx.size()) chk("t4_order", obs_idx[j], exp4[j]);
        for (int j = 1; j < 5; j++)
            if (j < obs_cyc.size()) chk("t4_gap", obs_cyc[j] - obs_cyc[j-1], 3);

        // 5: operands changed after grant must not affect the job
        set_ops(3, 16'h8001, 1'b1, 4'd15);
        req = 4'b1000;
        tick();
        chk("t5_ack", ack, 4'b1000);
        set_ops(3, 16'hFFFF, 1'b0, 4'd0);
        repeat (15) tick();
        tick();
        chk("t5_done", done, 4'b1000);
        chk("t5_result", result, 16'h0001);
        drain();

        // 6: reset mid-job aborts without done
        set_ops(1, 16'h00FF, 1'b0, 4'd8);
        req = 4'b0010;
        tick();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("t6_abort_done", done, 4'b0000);
        reset = 1'b1;
        set_ops(0, 16'h0003, 1'b0, 4'd2);
        req = 4'b0011;
        tick();
        chk("t6_first", ack, 4'b0001);
        repeat (3) tick();
        chk("t6_done", done, 4'b0001);
        chk("t6_result", result, 16'h000C);
        drain();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        set_ops(i, WIDTH'($urandom), 1'($urandom), CNT_W'($urandom));
                    end
                end else begin
                    if ($urandom_range(0, 7) == 0)
                        set_ops(i, WIDTH'($urandom), 1'($urandom), CNT_W'($urandom));
                    if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
                end
            end
            tick();
        end
        reset = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
